// File: rtl/xnor_cmp_pkg.sv
// Shared types and helpers for the serial XNOR comparator.
//   state_e            : FSM state encoding (IDLE, RUN, DONE)
//   chunk_popcount     : number of ones in the low n bits of a chunk
//   chunk_lowest_zero  : position of the lowest zero in the low n bits (0 if none)
package xnor_cmp_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // Helpers take a chunk zero-extended to CHUNK_MAX bits plus the live width n.
  localparam int unsigned CHUNK_MAX   = 64;
  localparam int unsigned CHUNK_CNT_W = 7;

  function automatic logic [CHUNK_CNT_W-1:0] chunk_popcount(
    input logic [CHUNK_MAX-1:0] x,
    input int unsigned          n
  );
    logic [CHUNK_CNT_W-1:0] cnt;
    cnt = '0;
    for (int unsigned i = 0; i < CHUNK_MAX; i++) begin
      if (i < n && x[i]) cnt = cnt + CHUNK_CNT_W'(1);
    end
    return cnt;
  endfunction

  function automatic logic [CHUNK_CNT_W-1:0] chunk_lowest_zero(
    input logic [CHUNK_MAX-1:0] x,
    input int unsigned          n
  );
    logic [CHUNK_CNT_W-1:0] idx;
    logic                   hit;
    idx = '0;
    hit = 1'b0;
    for (int unsigned i = 0; i < CHUNK_MAX; i++) begin
      if (i < n && !x[i] && !hit) begin
        idx = CHUNK_CNT_W'(i);
        hit = 1'b1;
      end
    end
    return idx;
  endfunction

endpackage

// File: rtl/xnor_serial_comparator_if.sv
// Request/result bus of the serial comparator.
//   master : requester (drives start_valid, a, b, res_ready)
//   slave  : comparator (drives start_ready, res_valid, equal, mismatch_idx, match_count)
interface xnor_serial_comparator_if #(
  parameter int unsigned WIDTH = 32
);
  localparam int unsigned IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int unsigned CNT_W = $clog2(WIDTH + 1);

  logic             start_valid;
  logic             start_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             res_valid;
  logic             res_ready;
  logic             equal;
  logic [IDX_W-1:0] mismatch_idx;
  logic [CNT_W-1:0] match_count;

  modport master (
    output start_valid, a, b, res_ready,
    input  start_ready, res_valid, equal, mismatch_idx, match_count
  );

  modport slave (
    input  start_valid, a, b, res_ready,
    output start_ready, res_valid, equal, mismatch_idx, match_count
  );
endinterface

// File: rtl/xnor_vector_gate.sv
// Combinational W-bit bitwise XNOR, one two-input cell per bit.
//   i_a, i_b : operand slices
//   o_y_c    : ~(i_a ^ i_b), 1 where the bits agree
module xnor_vector_gate #(
  parameter int unsigned W = 8
) (
  input  logic [W-1:0] i_a,
  input  logic [W-1:0] i_b,
  output logic [W-1:0] o_y_c
);
  for (genvar g = 0; g < W; g++) begin : g_bit
    assign o_y_c[g] = ~(i_a[g] ^ i_b[g]);
  end
endmodule

// File: rtl/xnor_serial_comparator.sv
// Multi-cycle equality comparator: scans CHUNK bits per cycle, LSB chunk first.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : slave side of the request/result bus (valid/ready both ways)
// Results: equal flag, lowest mismatching bit index, matching-bit count.
module xnor_serial_comparator
  import xnor_cmp_pkg::*;
#(
  parameter int unsigned WIDTH      = 32,
  parameter int unsigned CHUNK      = 8,
  parameter bit          EARLY_EXIT = 1'b1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  xnor_serial_comparator_if.slave bus
);
  localparam int unsigned NCHUNK = WIDTH / CHUNK;
  localparam int unsigned K_W    = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam int unsigned IDX_W  = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int unsigned CNT_W  = $clog2(WIDTH + 1);

  state_e           r_state, w_state_nxt;
  logic [WIDTH-1:0] r_a, r_b, w_a_nxt, w_b_nxt;
  logic [K_W-1:0]   r_k, w_k_nxt;
  logic             r_found, w_found_nxt;
  logic             r_equal, w_equal_nxt;
  logic             r_res_valid, w_res_valid_nxt;
  logic [IDX_W-1:0] r_idx, w_idx_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;

  logic [CHUNK-1:0]       w_x;
  logic                   w_chunk_mis;
  logic [CHUNK_CNT_W-1:0] w_pop;
  logic [CHUNK_CNT_W-1:0] w_lz;
  logic [IDX_W-1:0]       w_base;

  // Operands shift right each RUN cycle, so the current chunk is always the low slice.
  xnor_vector_gate #(.W(CHUNK)) u_gate (
    .i_a   (r_a[CHUNK-1:0]),
    .i_b   (r_b[CHUNK-1:0]),
    .o_y_c (w_x)
  );

  assign w_chunk_mis = ~&w_x;
  assign w_pop       = chunk_popcount(CHUNK_MAX'(w_x), CHUNK);
  assign w_lz        = chunk_lowest_zero(CHUNK_MAX'(w_x), CHUNK);
  assign w_base      = IDX_W'(r_k) * IDX_W'(CHUNK);

  // Next-state and datapath update.
  always_comb begin
    w_state_nxt     = r_state;
    w_a_nxt         = r_a;
    w_b_nxt         = r_b;
    w_k_nxt         = r_k;
    w_found_nxt     = r_found;
    w_equal_nxt     = r_equal;
    w_res_valid_nxt = r_res_valid;
    w_idx_nxt       = r_idx;
    w_cnt_nxt       = r_cnt;
    case (r_state)
      IDLE: begin
        if (bus.start_valid) begin
          w_a_nxt     = bus.a;
          w_b_nxt     = bus.b;
          w_k_nxt     = '0;
          w_found_nxt = 1'b0;
          w_equal_nxt = 1'b0;
          w_idx_nxt   = '0;
          w_cnt_nxt   = '0;
          w_state_nxt = RUN;
        end
      end
      RUN: begin
        w_cnt_nxt = r_cnt + CNT_W'(w_pop);
        w_a_nxt   = r_a >> CHUNK;
        w_b_nxt   = r_b >> CHUNK;
        // First mismatching chunk fixes the index for the rest of the scan.
        if (w_chunk_mis && !r_found) begin
          w_found_nxt = 1'b1;
          w_idx_nxt   = w_base + IDX_W'(w_lz);
        end
        if (r_k == K_W'(NCHUNK - 1) || (EARLY_EXIT && w_chunk_mis)) begin
          w_state_nxt     = DONE;
          w_res_valid_nxt = 1'b1;
          w_equal_nxt     = ~(r_found | w_chunk_mis);
        end else begin
          w_k_nxt = r_k + K_W'(1);
        end
      end
      DONE: begin
        if (bus.res_ready) begin
          w_state_nxt     = IDLE;
          w_res_valid_nxt = 1'b0;
        end
      end
      default: begin
        w_state_nxt     = IDLE;
        w_res_valid_nxt = 1'b0;
      end
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_a         <= '0;
      r_b         <= '0;
      r_k         <= '0;
      r_found     <= 1'b0;
      r_equal     <= 1'b0;
      r_res_valid <= 1'b0;
      r_idx       <= '0;
      r_cnt       <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_a         <= w_a_nxt;
      r_b         <= w_b_nxt;
      r_k         <= w_k_nxt;
      r_found     <= w_found_nxt;
      r_equal     <= w_equal_nxt;
      r_res_valid <= w_res_valid_nxt;
      r_idx       <= w_idx_nxt;
      r_cnt       <= w_cnt_nxt;
    end
  end

  // Ready is a decode of the state register, so it reads 1 during reset.
  assign bus.start_ready  = (r_state == IDLE);
  assign bus.res_valid    = r_res_valid;
  assign bus.equal        = r_equal;
  assign bus.mismatch_idx = r_idx;
  assign bus.match_count  = r_cnt;

endmodule

// File: tb/tb_xnor_serial_comparator.sv
module tb_xnor_serial_comparator;
  localparam int unsigned WIDTH  = 32;
  localparam int unsigned CHUNK  = 8;
  localparam int unsigned NCHUNK = WIDTH / CHUNK;
  localparam int unsigned IW     = $clog2(WIDTH);
  localparam int unsigned CW     = $clog2(WIDTH + 1);
  localparam int unsigned BUDGET = 20;

  typedef struct {
    int unsigned   lat;
    logic          eq;
    logic [IW-1:0] idx;
    logic [CW-1:0] cnt;
  } exp_t;

  typedef struct {
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    exp_t             e1;
    exp_t             e0;
  } vec_t;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;
  exp_t q1[$];
  exp_t q0[$];
  exp_t last1, last0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  xnor_serial_comparator_if #(.WIDTH(WIDTH)) if1 ();
  xnor_serial_comparator_if #(.WIDTH(WIDTH)) if0 ();

  xnor_serial_comparator #(.WIDTH(WIDTH), .CHUNK(CHUNK), .EARLY_EXIT(1'b1)) u_ee1 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (if1.slave)
  );

  xnor_serial_comparator #(.WIDTH(WIDTH), .CHUNK(CHUNK), .EARLY_EXIT(1'b0)) u_ee0 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (if0.slave)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: walk chunks LSB first, bit by bit.
  function automatic exp_t model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                 input bit ee);
    exp_t e;
    bit   found;
    bit   hit;
    int   i;
    found = 1'b0;
    e.lat = NCHUNK;
    e.idx = '0;
    e.cnt = '0;
    for (int k = 0; k < int'(NCHUNK); k++) begin
      hit = 1'b0;
      for (int j = 0; j < int'(CHUNK); j++) begin
        i = k * int'(CHUNK) + j;
        if (a[i] == b[i]) e.cnt = e.cnt + CW'(1);
        else begin
          hit = 1'b1;
          if (!found) begin
            found = 1'b1;
            e.idx = IW'(i);
          end
        end
      end
      if (hit && ee) begin
        e.lat = k + 1;
        break;
      end
    end
    e.eq = !found;
    return e;
  endfunction

  function automatic exp_t mk(input int unsigned lat, input logic eq, input int unsigned idx,
                              input int unsigned cnt);
    exp_t e;
    e.lat = lat;
    e.eq  = eq;
    e.idx = IW'(idx);
    e.cnt = CW'(cnt);
    return e;
  endfunction

  task automatic launch(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                        input exp_t e1, input exp_t e0);
    @(negedge clk);
    chk("start_ready_ee1", if1.start_ready, 1'b1);
    chk("start_ready_ee0", if0.start_ready, 1'b1);
    if1.a = a; if1.b = b; if1.start_valid = 1'b1;
    if0.a = a; if0.b = b; if0.start_valid = 1'b1;
    q1.push_back(e1);
    q0.push_back(e0);
    @(posedge clk);
    #1;
    if1.start_valid = 1'b0;
    if0.start_valid = 1'b0;
  endtask

  task automatic cmp_dut(input string tag, input bit seen, input int unsigned lat,
                         input exp_t e, input logic eq, input logic [IW-1:0] idx,
                         input logic [CW-1:0] cnt);
    chk({tag, "_result_seen"}, 64'(seen), 64'(1));
    chk({tag, "_latency"}, 64'(lat), 64'(e.lat));
    chk({tag, "_equal"}, 64'(eq), 64'(e.eq));
    chk({tag, "_mismatch_idx"}, 64'(idx), 64'(e.idx));
    chk({tag, "_match_count"}, 64'(cnt), 64'(e.cnt));
  endtask

  // Waits for both results (bounded) and scores them against the queued expectations.
  task automatic wait_results();
    bit          s1, s0;
    int unsigned l1, l0;
    s1 = 1'b0; s0 = 1'b0; l1 = 0; l0 = 0;
    for (int unsigned c = 1; c <= BUDGET && !(s1 && s0); c++) begin
      @(posedge clk);
      #1;
      if (!s1 && if1.res_valid) begin s1 = 1'b1; l1 = c; end
      if (!s0 && if0.res_valid) begin s0 = 1'b1; l0 = c; end
    end
    last1 = (q1.size() > 0) ? q1.pop_front() : mk(0, 1'bx, 0, 0);
    last0 = (q0.size() > 0) ? q0.pop_front() : mk(0, 1'bx, 0, 0);
    cmp_dut("ee1", s1, l1, last1, if1.equal, if1.mismatch_idx, if1.match_count);
    cmp_dut("ee0", s0, l0, last0, if0.equal, if0.mismatch_idx, if0.match_count);
  endtask

  task automatic release_res();
    if1.res_ready = 1'b1;
    if0.res_ready = 1'b1;
    @(posedge clk);
    #1;
    if1.res_ready = 1'b0;
    if0.res_ready = 1'b0;
    chk("released_res_valid_ee1", if1.res_valid, 1'b0);
    chk("released_res_valid_ee0", if0.res_valid, 1'b0);
    chk("released_start_ready_ee1", if1.start_ready, 1'b1);
    chk("released_start_ready_ee0", if0.start_ready, 1'b1);
  endtask

  task automatic run_vec(input vec_t v);
    launch(v.a, v.b, v.e1, v.e0);
    wait_results();
    release_res();
  endtask

  vec_t             tbl[5];
  vec_t             v;
  logic [WIDTH-1:0] na, nb;
  int               stray;

  initial begin
    checks = 0;
    errors = 0;
    rst_n  = 1'b0;
    if1.start_valid = 1'b0; if1.res_ready = 1'b0; if1.a = '0; if1.b = '0;
    if0.start_valid = 1'b0; if0.res_ready = 1'b0; if0.a = '0; if0.b = '0;

    tbl[0] = '{a: 32'hDEADBEEF, b: 32'hDEADBEEF, e1: mk(4, 1, 0, 32), e0: mk(4, 1, 0, 32)};
    tbl[1] = '{a: 32'h00000000, b: 32'h00010000, e1: mk(3, 0, 16, 23), e0: mk(4, 0, 16, 31)};
    tbl[2] = '{a: 32'hFFFFFFFF, b: 32'h7FFFFFFE, e1: mk(1, 0, 0, 7), e0: mk(4, 0, 0, 30)};
    tbl[3] = '{a: 32'h80000000, b: 32'h00000000, e1: mk(4, 0, 31, 31), e0: mk(4, 0, 31, 31)};
    tbl[4] = '{a: 32'h0000FF00, b: 32'h00000000, e1: mk(2, 0, 8, 8), e0: mk(4, 0, 8, 24)};

    // Reset values
    #2;
    chk("rst_res_valid", if1.res_valid, 1'b0);
    chk("rst_equal", if1.equal, 1'b0);
    chk("rst_mismatch_idx", 64'(if1.mismatch_idx), 64'(0));
    chk("rst_match_count", 64'(if0.match_count), 64'(0));
    chk("rst_start_ready", if0.start_ready, 1'b1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    for (int n = 0; n < 5; n++) run_vec(tbl[n]);

    // Random operands: equal, single-bit flip, unrelated
    for (int n = 0; n < 9; n++) begin
      v.a = $urandom;
      case (n % 3)
        0:       v.b = v.a;
        1:       v.b = v.a ^ (WIDTH'(1) << $urandom_range(WIDTH - 1, 0));
        default: v.b = $urandom;
      endcase
      v.e1 = model(v.a, v.b, 1'b1);
      v.e0 = model(v.a, v.b, 1'b0);
      run_vec(v);
    end

    // Backpressure: results held, new requests refused while in DONE
    launch(tbl[1].a, tbl[1].b, tbl[1].e1, tbl[1].e0);
    wait_results();
    na = 32'h12345678;
    nb = 32'h12345679;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      if1.a = na; if1.b = nb; if1.start_valid = 1'b1;
      if0.a = na; if0.b = nb; if0.start_valid = 1'b1;
      @(posedge clk);
      #1;
      chk("bp_res_valid_ee1", if1.res_valid, 1'b1);
      chk("bp_res_valid_ee0", if0.res_valid, 1'b1);
      chk("bp_start_ready_ee1", if1.start_ready, 1'b0);
      chk("bp_start_ready_ee0", if0.start_ready, 1'b0);
      chk("bp_count_ee1", 64'(if1.match_count), 64'(last1.cnt));
      chk("bp_count_ee0", 64'(if0.match_count), 64'(last0.cnt));
      chk("bp_idx_ee1", 64'(if1.mismatch_idx), 64'(last1.idx));
      chk("bp_equal_ee0", if0.equal, last0.eq);
    end
    if1.start_valid = 1'b0;
    if0.start_valid = 1'b0;
    release_res();
    v.a = na; v.b = nb;
    v.e1 = mk(1, 0, 0, 7);
    v.e0 = mk(4, 0, 0, 31);
    run_vec(v);

    // Reset in RUN after chunk 1: abort without a result
    @(negedge clk);
    if1.a = 32'hDEADBEEF; if1.b = 32'hDEADBEEF; if1.start_valid = 1'b1;
    if0.a = 32'hDEADBEEF; if0.b = 32'hDEADBEEF; if0.start_valid = 1'b1;
    @(posedge clk);
    #1;
    if1.start_valid = 1'b0;
    if0.start_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("mid_count_before_rst", 64'(if1.match_count), 64'(16));
    rst_n = 1'b0;
    #1;
    chk("mid_rst_res_valid", if1.res_valid, 1'b0);
    chk("mid_rst_count_ee1", 64'(if1.match_count), 64'(0));
    chk("mid_rst_count_ee0", 64'(if0.match_count), 64'(0));
    chk("mid_rst_start_ready", if1.start_ready, 1'b1);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    stray = 0;
    for (int c = 0; c < 6; c++) begin
      @(posedge clk);
      #1;
      if (if1.res_valid || if0.res_valid) stray++;
    end
    chk("no_result_after_rst", 64'(stray), 64'(0));
    run_vec(tbl[0]);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/xnor_serial_comparator.md
Name: xnor_serial_comparator

Overview:
- Parametrised, multi-cycle equality comparator built on bitwise XNOR.
- Compares two WIDTH-bit operands CHUNK bits per cycle, LSB chunk first.
- Reports the equality flag, the index of the lowest mismatching bit, and the count of matching bits.
- Sits behind the gate-level primitives as the first sequential consumer; valid/ready on both sides.

Parameters:
- WIDTH, 32, operand width in bits; must be a multiple of CHUNK.
- CHUNK, 8, bits compared per cycle; 1 <= CHUNK <= WIDTH.
- EARLY_EXIT, 1, if 1, stop scanning after the first chunk containing a mismatch; if 0, always scan all chunks.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start_valid  in  1  request valid.
- start_ready  out  1  block can accept a request.
- a  in  WIDTH  operand A; sampled on accept.
- b  in  WIDTH  operand B; sampled on accept.
- res_valid  out  1  result valid.
- res_ready  in  1  consumer accepts the result.
- equal  out  1  1 when all scanned bits match.
- mismatch_idx  out  $clog2(WIDTH)  lowest bit index where a != b; 0 when equal=1.
- match_count  out  $clog2(WIDTH+1)  number of matching bits in the chunks scanned.

Behaviour:
- Clock and reset: one clock, clk; reset rst_n is asynchronous and active-low.
- NCHUNK = WIDTH/CHUNK.
- State machine: IDLE, RUN, DONE.
  - Reset enters IDLE.
  - Reset values: res_valid=0, equal=0, mismatch_idx=0, match_count=0, chunk counter=0, operand registers=0.
- start_ready = (state==IDLE); combinationally decoded, so it reads 1 while in reset. The bench must not drive start_valid while rst_n is low.
- Accept: start_valid && start_ready at a rising edge.
  - Latches a and b.
  - Clears match_count, mismatch_idx and the mismatch-found flag.
  - Sets the chunk counter to 0 and goes to RUN.
- RUN, each cycle, chunk k covers bits [k*CHUNK +: CHUNK]:
  - x = ~(a_chunk ^ b_chunk).
  - match_count += popcount(x).
  - On the first chunk containing a zero in x, mismatch_idx = k*CHUNK + (lowest zero position of x). It is never overwritten afterwards.
  - Transition to DONE when k == NCHUNK-1, or when EARLY_EXIT=1 and chunk k contains a mismatch. Otherwise k increments.
- DONE:
  - res_valid=1.
  - equal = ~mismatch_found.
  - Outputs held stable until res_ready=1, which returns to IDLE at the next edge.
- Latency from the accept edge to res_valid high:
  - NCHUNK cycles when there is no early exit.
  - (k+1) cycles on an early exit at chunk k.
- No overlap: no new request is accepted in RUN or DONE. start_valid is ignored there and the operands are not resampled.
- Result outputs keep their last values in IDLE until the next accept clears them. res_valid is 0 in IDLE.
- Arithmetic: match_count never exceeds WIDTH, so no wrap. The chunk counter is $clog2(NCHUNK) bits wide, minimum 1.
- Reset mid-operation, in any state: immediately IDLE, res_valid=0, all results and counters cleared, no result emitted.
- CHUNK==WIDTH gives a single-cycle RUN, with res_valid 1 cycle after accept.

Decomposition:
- Shared package xnor_cmp_pkg holds:
  - the state enum {IDLE, RUN, DONE};
  - helper functions for popcount and lowest-zero index, parametrised on CHUNK.
- One sub-module, xnor_vector_gate: combinational CHUNK-wide bitwise XNOR, built from the team's gate-level cells, instantiated once for the current chunk.
- Muxing, counting and the FSM stay in the top level.

Test Plan (WIDTH=32, CHUNK=8):
1. EARLY_EXIT=1, a=b=0xDEADBEEF -> res_valid 4 cycles after accept; equal=1, mismatch_idx=0, match_count=32.
2. EARLY_EXIT=1, a=0x00000000, b=0x00010000 -> res_valid 3 cycles after accept; equal=0, mismatch_idx=16, match_count=23.
3. EARLY_EXIT=0, same operands as case 2 -> res_valid 4 cycles after accept; equal=0, mismatch_idx=16, match_count=31.
4. a=0xFFFFFFFF, b=0x7FFFFFFE:
   - EARLY_EXIT=0 -> 4 cycles; mismatch_idx=0, match_count=30.
   - EARLY_EXIT=1 -> 1 cycle; mismatch_idx=0, match_count=7.
5. Backpressure: hold res_ready=0 for 5 cycles in DONE while start_valid=1 with new operands:
   - -> res_valid stays 1, outputs stable, start_ready=0, new operands not taken.
   - res_ready=1 -> IDLE next cycle, start_ready=1; the next request is accepted and produces a correct result.
6. Drop rst_n for 1 cycle in RUN, after chunk 1 -> res_valid=0, match_count=0, start_ready=1 asynchronously; no result is emitted. A subsequent compare (case 1 operands) completes correctly.
